// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding, Booth digit codes and the recoding helper.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITER  = MUL_WIDTH / 2;
    localparam int MUL_ACCW  = MUL_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        BOOTH_ZERO,
        BOOTH_P1,
        BOOTH_P2,
        BOOTH_M1,
        BOOTH_M2
    } booth_t;

    // Radix-4 recoding of {m[2i+1], m[2i], m[2i-1]} into a digit in {-2..+2}.
    function automatic booth_t booth_digit(input logic [2:0] b);
        booth_t d;
        case (b)
            3'b001, 3'b010: d = BOOTH_P1;
            3'b011:         d = BOOTH_P2;
            3'b100:         d = BOOTH_M2;
            3'b101, 3'b110: d = BOOTH_M1;
            default:        d = BOOTH_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_enc.sv
// Combinational Booth partial-product generator: turns three multiplier bits
// and the guarded multiplicand into digit*mcand in two's complement.
module booth_enc
    import mul_pkg::*;
#(
    parameter int ACCW = MUL_ACCW
) (
    input  logic [2:0]      bits_i,
    input  logic [ACCW-1:0] mcand_i,
    output logic [ACCW-1:0] pp_o
);

    // Negation is invert-plus-one after doubling; the two guard bits keep -2*min in range.
    always_comb begin
        pp_o = '0;
        case (booth_digit(bits_i))
            BOOTH_P1: pp_o = mcand_i;
            BOOTH_P2: pp_o = mcand_i << 1;
            BOOTH_M1: pp_o = ~mcand_i + ACCW'(1);
            BOOTH_M2: pp_o = ~(mcand_i << 1) + ACCW'(1);
            default:  pp_o = '0;
        endcase
    end

endmodule

// File: rtl/mul32_seq.sv
// Sequential signed multiplier, radix-4 Booth, two multiplier bits per cycle.
// Define MUL_UNSIGNED_EN to add the is_unsigned port (one extra Booth iteration).
module mul32_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
`ifdef MUL_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int ITER = WIDTH / 2;
    localparam int ACCW = WIDTH + 2;
`ifdef MUL_UNSIGNED_EN
    localparam int NITER = ITER + 1;
    localparam int MPW   = WIDTH + 3;
`else
    localparam int NITER = ITER;
    localparam int MPW   = WIDTH + 1;
`endif
    localparam int CW   = ACCW + MPW;
    localparam int CNTW = $clog2(NITER + 1);

    state_t            state_q;
    logic [ACCW-1:0]   mcand_q;
    logic [ACCW-1:0]   acc_q;
    logic [MPW-1:0]    mplier_q;
    logic [CNTW-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;

    logic [ACCW-1:0]   pp;
    logic [ACCW-1:0]   sum_d;
    logic signed [CW-1:0] comb_d;
    logic signed [CW-1:0] shifted_d;
    logic              signA;
    logic              signM;
    logic [ACCW-1:0]   mcand_d;
    logic [MPW-1:0]    mplier_d;

    booth_enc #(.ACCW(ACCW)) u_booth (
        .bits_i  (mplier_q[2:0]),
        .mcand_i (mcand_q),
        .pp_o    (pp)
    );

    assign sum_d     = acc_q + pp;
    assign comb_d    = {sum_d, mplier_q};
    assign shifted_d = comb_d >>> 2;

`ifdef MUL_UNSIGNED_EN
    assign signA    = A[WIDTH-1] & ~is_unsigned;
    assign signM    = M[WIDTH-1] & ~is_unsigned;
    assign mplier_d = {{2{signM}}, M, 1'b0};
`else
    assign signA    = A[WIDTH-1];
    assign signM    = M[WIDTH-1];
    assign mplier_d = {M, 1'b0};
`endif
    assign mcand_d = {{2{signA}}, A};

    // After the last shift the product sits one bit above the bottom of {acc, mplier}.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    {acc_q, mplier_q} <= shifted_d;
                    cnt_q             <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(NITER - 1)) begin
                        {hi_q, lo_q} <= shifted_d[2*WIDTH:1];
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
